// File: rtl/sfifo_pkg.sv
// Shared types and widths for the 16-bit synchronous FIFO and its byte-wide drain.
package sfifo_pkg;

  localparam int unsigned FIFO_DW = 16;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BYTE0 = 2'd2,
    ST_BYTE1 = 2'd3
  } drain_state_e;

endpackage

// File: rtl/fifo_byte_drain.sv
// Pops 16-bit words from the FIFO read port and re-emits each as two bytes
// on an 8-bit valid/ready stream, with a drained-word counter and sticky underflow flag.
module fifo_byte_drain
  import sfifo_pkg::*;
#(
  parameter bit          HI_FIRST = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic               fifo_rd,
  input  logic [FIFO_DW-1:0] fifo_dout,
  input  logic               fifo_empty,
  input  logic               fifo_udfl,
  output logic [BYTE_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   word_cnt,
  output logic               err,
  input  logic               err_clr,
  output logic               busy
);

  drain_state_e       state;
  logic [FIFO_DW-1:0] hold;
  logic               xfer;
  logic [BYTE_W-1:0]  first_byte;
  logic [BYTE_W-1:0]  second_byte;

  assign xfer = out_valid && out_ready;

  // First byte comes straight off the FIFO data bus in WAIT; second from the holding register.
  assign first_byte  = HI_FIRST ? fifo_dout[FIFO_DW-1:BYTE_W] : fifo_dout[BYTE_W-1:0];
  assign second_byte = HI_FIRST ? hold[BYTE_W-1:0] : hold[FIFO_DW-1:BYTE_W];

  // Read strobe: idle pop, or back-to-back prefetch on the final byte handshake.
  always_comb begin
    fifo_rd = 1'b0;
    if (!rst && !fifo_empty) begin
      fifo_rd = (state == ST_IDLE) || ((state == ST_BYTE1) && xfer);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      word_cnt  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_rd) begin
            state <= ST_WAIT;
            busy  <= 1'b1;
          end
        end
        ST_WAIT: begin
          hold      <= fifo_dout;
          out_valid <= 1'b1;
          out_data  <= first_byte;
          state     <= ST_BYTE0;
        end
        ST_BYTE0: begin
          if (xfer) begin
            out_data <= second_byte;
            state    <= ST_BYTE1;
          end
        end
        ST_BYTE1: begin
          if (xfer) begin
            word_cnt  <= word_cnt + CNT_W'(1);
            out_valid <= 1'b0;
            out_data  <= '0;
            if (fifo_rd) begin
              state <= ST_WAIT;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky underflow flag; a clear wins over a same-cycle set.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (err_clr) begin
      err <= 1'b0;
    end else if (fifo_udfl) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_byte_drain.sv
// Directed bench for fifo_byte_drain: three instances (hi-first, lo-first, 4-bit counter)
// each fed by a small behavioural FIFO.
module tb_fifo_byte_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instance 0: HI_FIRST=1, CNT_W=16
  logic        rd0, empty0, valid0, err0, busy0;
  logic        udfl0 = 1'b0, clr0 = 1'b0, ready0 = 1'b1;
  logic [15:0] dout0 = '0;
  logic [7:0]  data0;
  logic [15:0] cnt0;
  logic [15:0] mem0 [0:255];
  int          wp0 = 0, rp0 = 0;

  // Instance 1: HI_FIRST=0
  logic        rd1, empty1, valid1, err1, busy1;
  logic        udfl1 = 1'b0, clr1 = 1'b0, ready1 = 1'b1;
  logic [15:0] dout1 = '0;
  logic [7:0]  data1;
  logic [15:0] cnt1;
  logic [15:0] mem1 [0:31];
  int          wp1 = 0, rp1 = 0;

  // Instance 2: CNT_W=4
  logic        rd2, empty2, valid2, err2, busy2;
  logic        udfl2 = 1'b0, clr2 = 1'b0, ready2 = 1'b1;
  logic [15:0] dout2 = '0;
  logic [7:0]  data2;
  logic [3:0]  cnt2;
  logic [15:0] mem2 [0:31];
  int          wp2 = 0, rp2 = 0;

  fifo_byte_drain #(.HI_FIRST(1'b1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .fifo_rd(rd0), .fifo_dout(dout0), .fifo_empty(empty0),
    .fifo_udfl(udfl0), .out_data(data0), .out_valid(valid0), .out_ready(ready0),
    .word_cnt(cnt0), .err(err0), .err_clr(clr0), .busy(busy0));

  fifo_byte_drain #(.HI_FIRST(1'b0), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .fifo_rd(rd1), .fifo_dout(dout1), .fifo_empty(empty1),
    .fifo_udfl(udfl1), .out_data(data1), .out_valid(valid1), .out_ready(ready1),
    .word_cnt(cnt1), .err(err1), .err_clr(clr1), .busy(busy1));

  fifo_byte_drain #(.HI_FIRST(1'b1), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .fifo_rd(rd2), .fifo_dout(dout2), .fifo_empty(empty2),
    .fifo_udfl(udfl2), .out_data(data2), .out_valid(valid2), .out_ready(ready2),
    .word_cnt(cnt2), .err(err2), .err_clr(clr2), .busy(busy2));

  // Behavioural FIFOs: combinational empty, dout valid the cycle after an accepted read.
  assign empty0 = (wp0 == rp0);
  assign empty1 = (wp1 == rp1);
  assign empty2 = (wp2 == rp2);

  always @(posedge clk) begin
    if (rd0 && !empty0) begin dout0 <= mem0[rp0]; rp0 <= rp0 + 1; end
    if (rd1 && !empty1) begin dout1 <= mem1[rp1]; rp1 <= rp1 + 1; end
    if (rd2 && !empty2) begin dout2 <= mem2[rp2]; rp2 <= rp2 + 1; end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Byte monitor and protocol watch on instance 0, sampled on the falling edge.
  logic [7:0] rx0 [$];
  int         rx_cyc [$];
  logic       pv = 1'b0, pr = 1'b0, prst = 1'b1;
  logic [7:0] pd = '0;
  int         stalls = 0, rd_viol = 0, idle_viol = 0;

  always @(negedge clk) begin
    if (!prst && pv && !pr) begin
      stalls++;
      check("stall_valid", valid0, 1'b1);
      check("stall_data", data0, pd);
    end
    if (valid0 && ready0 && !rst) begin
      rx0.push_back(data0);
      rx_cyc.push_back(cyc);
    end
    if ((rd0 && empty0) || (rd1 && empty1) || (rd2 && empty2)) rd_viol++;
    if ((!valid0 && data0 != 8'h00) || (!valid1 && data1 != 8'h00)) idle_viol++;
    pv   = valid0;
    pr   = ready0;
    pd   = data0;
    prst = rst;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic push0(input logic [15:0] w);
    @(posedge clk); #1;
    mem0[wp0] = w;
    wp0++;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp4 [$];
    logic [15:0] w;

    // Reset values
    @(negedge clk);
    check("rst_rd", rd0, 1'b0);
    check("rst_valid", valid0, 1'b0);
    check("rst_data", data0, 8'h00);
    check("rst_cnt", cnt0, 16'd0);
    check("rst_err", err0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single word, hi byte first, exact cycle timing
    push0(16'hA5C3);
    @(negedge clk);
    check("t1_rd", rd0, 1'b1);
    check("t1_idle_busy", busy0, 1'b0);
    @(negedge clk);
    check("t1_wait_valid", valid0, 1'b0);
    check("t1_wait_busy", busy0, 1'b1);
    check("t1_wait_rd", rd0, 1'b0);
    @(negedge clk);
    check("t1_b0_valid", valid0, 1'b1);
    check("t1_b0_data", data0, 8'hA5);
    @(negedge clk);
    check("t1_b1_valid", valid0, 1'b1);
    check("t1_b1_data", data0, 8'hC3);
    @(negedge clk);
    check("t1_end_valid", valid0, 1'b0);
    check("t1_end_data", data0, 8'h00);
    check("t1_end_cnt", cnt0, 16'd1);
    check("t1_end_busy", busy0, 1'b0);

    // Byte order, lo byte first
    @(posedge clk); #1;
    mem1[wp1] = 16'hA5C3;
    wp1++;
    for (int k = 0; k < 10 && !valid1; k++) @(negedge clk);
    check("t2_valid", valid1, 1'b1);
    check("t2_b0_data", data1, 8'hC3);
    @(negedge clk);
    check("t2_b1_data", data1, 8'hA5);
    @(negedge clk);
    check("t2_cnt", cnt1, 16'd1);
    check("t2_busy", busy1, 1'b0);

    // Burst of 64 words at full rate
    do_reset();
    rx0.delete();
    rx_cyc.delete();
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) mem0[wp0 + i] = 16'(i);
    wp0 += 64;
    for (int k = 0; k < 600 && cnt0 != 16'd64; k++) @(negedge clk);
    check("t3_cnt", cnt0, 16'd64);
    check("t3_err", err0, 1'b0);
    check("t3_nbytes", rx0.size(), 128);
    if (rx0.size() == 128) begin
      for (int i = 0; i < 64; i++) begin
        check("t3_hi", rx0[2*i], 8'h00);
        check("t3_lo", rx0[2*i+1], 8'(i));
      end
      check("t3_span", rx_cyc[127] - rx_cyc[0], 190);
    end

    // Random backpressure
    do_reset();
    rx0.delete();
    rx_cyc.delete();
    stalls = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      w = 16'(16'h1357 * (i + 1) + 16'h00A1);
      mem0[wp0 + i] = w;
      exp4.push_back(w);
    end
    wp0 += 20;
    for (int k = 0; k < 2000 && cnt0 != 16'd20; k++) begin
      @(posedge clk); #1;
      ready0 = 1'($urandom_range(0, 1));
    end
    ready0 = 1'b1;
    @(negedge clk);
    check("t4_cnt", cnt0, 16'd20);
    check("t4_stalls_seen", stalls > 0, 1'b1);
    check("t4_nbytes", rx0.size(), 40);
    if (rx0.size() == 40) begin
      for (int i = 0; i < 20; i++) begin
        w = exp4[i];
        check("t4_hi", rx0[2*i], w[15:8]);
        check("t4_lo", rx0[2*i+1], w[7:0]);
      end
    end

    // Reset while stalled in the second byte, with the FIFO refilled
    do_reset();
    rx0.delete();
    rx_cyc.delete();
    ready0 = 1'b0;
    push0(16'hBEEF);
    for (int k = 0; k < 10 && !valid0; k++) @(negedge clk);
    check("t5_b0_valid", valid0, 1'b1);
    @(posedge clk); #1;
    ready0 = 1'b1;
    @(posedge clk); #1;
    ready0 = 1'b0;
    mem0[wp0] = 16'h1234;
    wp0++;
    @(negedge clk);
    check("t5_b1_data", data0, 8'hEF);
    check("t5_stall_rd", rd0, 1'b0);
    check("t5_stall_busy", busy0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("t5_rd_in_rst", rd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_valid", valid0, 1'b0);
    check("t5_data", data0, 8'h00);
    check("t5_cnt", cnt0, 16'd0);
    check("t5_busy", busy0, 1'b0);
    @(posedge clk); #1;
    ready0 = 1'b1;
    for (int k = 0; k < 20 && cnt0 != 16'd1; k++) @(negedge clk);
    check("t5_cnt_after", cnt0, 16'd1);
    check("t5_nbytes", rx0.size(), 3);
    if (rx0.size() == 3) begin
      check("t5_first", rx0[0], 8'hBE);
      check("t5_next_hi", rx0[1], 8'h12);
      check("t5_next_lo", rx0[2], 8'h34);
    end

    // Sticky error flag
    @(posedge clk); #1;
    udfl0 = 1'b1;
    @(posedge clk); #1;
    udfl0 = 1'b0;
    @(negedge clk);
    check("t6_set", err0, 1'b1);
    repeat (3) @(negedge clk);
    check("t6_held", err0, 1'b1);
    @(posedge clk); #1;
    clr0 = 1'b1;
    @(posedge clk); #1;
    clr0 = 1'b0;
    @(negedge clk);
    check("t6_clr", err0, 1'b0);
    @(posedge clk); #1;
    clr0  = 1'b1;
    udfl0 = 1'b1;
    @(posedge clk); #1;
    clr0  = 1'b0;
    udfl0 = 1'b0;
    @(negedge clk);
    check("t6_clr_wins", err0, 1'b0);
    @(negedge clk);
    check("t6_clr_wins_after", err0, 1'b0);

    // 4-bit counter wraps after 17 words
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) mem2[wp2 + i] = 16'(16'h0100 + i);
    wp2 += 17;
    @(negedge clk);
    for (int k = 0; k < 200 && !(empty2 && !busy2); k++) @(negedge clk);
    check("t7_drained", empty2 && !busy2, 1'b1);
    check("t7_cnt_wrap", cnt2, 4'd1);

    check("rd_while_empty", rd_viol, 0);
    check("data_when_idle", idle_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_byte_drain.md
# fifo_byte_drain

Read-side consumer for the 16-bit synchronous FIFO. It pops 16-bit words through the FIFO read port (`rd`/`dout`/`empty`) and re-emits each word as two bytes on an 8-bit valid/ready stream toward the byte-wide link. Byte order is parameterised. A drained-word counter and a sticky underflow error are provided for status readout.

## Interface
- `HI_FIRST`, default 1: 1 = bits [15:8] emitted first; 0 = bits [7:0] first.
- `CNT_W`, default 16: width of the drained-word counter.

- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `fifo_rd` out 1: read strobe to the FIFO `rd` input.
- `fifo_dout` in 16: FIFO `dout`; valid the cycle after an accepted read.
- `fifo_empty` in 1: FIFO `empty`, combinational.
- `fifo_udfl` in 1: FIFO `udfl`, monitored only.
- `out_data` out 8: byte to the downstream stage.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts the byte.
- `word_cnt` out CNT_W: words fully emitted (both bytes), wraps modulo 2^CNT_W.
- `err` out 1: sticky, set when `fifo_udfl` is seen high.
- `err_clr` in 1: clears `err`.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, BYTE0, BYTE1.
- **IDLE**
  - `fifo_rd = !fifo_empty`.
  - If `fifo_rd` is high, go to WAIT.
- **WAIT**
  - Capture `fifo_dout` into the 16-bit holding register `hold`.
  - Go to BYTE0.
- **BYTE0**
  - `out_valid = 1`.
  - `out_data` = first byte of `hold` (per `HI_FIRST`).
  - On `out_valid && out_ready`, go to BYTE1.
- **BYTE1**
  - `out_valid = 1`; `out_data` = second byte.
  - On handshake: increment `word_cnt`.
  - On handshake with `!fifo_empty`: also assert `fifo_rd` and go to WAIT (back-to-back prefetch).
  - On handshake with `fifo_empty`: go to IDLE.
- `fifo_rd` is combinational from state, `fifo_empty` and `out_ready`.
  - It is never asserted while `fifo_empty` is high, outside IDLE/BYTE1, or during `rst`.
- `out_data` and `out_valid` must not change while `out_valid && !out_ready` (AXI-style hold). `out_valid` never drops without a handshake.
- `out_data` reads 8'h00 when `out_valid` is low.
- `err` is set on any cycle with `fifo_udfl` high.
  - `err_clr` has priority over a set in the same cycle.
  - `err` stays set until `err_clr`.
- Counter arithmetic: `word_cnt` is unsigned, `+1` modulo 2^CNT_W, with no saturation.

## Timing
- Reset values: `fifo_rd` 0, `out_valid` 0, `out_data` 8'h00, `word_cnt` 0, `err` 0, `busy` 0, state IDLE, `hold` 16'h0000.
- Read latency: `fifo_rd` in cycle N, word in `hold` at the end of N+1, first byte valid in N+2.
- Throughput: with `out_ready` held high and the FIFO non-empty, one word per 3 cycles (byte, byte, WAIT).
- Reset mid-operation: a word already popped but not fully emitted is discarded. `word_cnt` does not count it.
- Downstream stall in BYTE1 with the FIFO refilling: no read is issued until the handshake.
- `fifo_empty` rising during BYTE0: no effect; the held word is still emitted.
- `fifo_udfl` high together with `err_clr`: `err` ends the cycle at 0.

## Structure
- Shared package `sfifo_pkg` holds:
  - the FSM state enum (`ST_IDLE`, `ST_WAIT`, `ST_BYTE0`, `ST_BYTE1`, 2-bit encoding);
  - the localparams `FIFO_DW = 16` and `BYTE_W = 8`.
- No sub-module is required. The byte-select mux is kept inline.
- The top-level integration connects `fifo_rd`/`fifo_dout`/`fifo_empty`/`fifo_udfl` directly to the FIFO's `rd`/`dout`/`empty`/`udfl`.

## Test plan
1. **Single word.** Write 16'hA5C3 to the FIFO; hold `out_ready` = 1, `HI_FIRST` = 1.
   - Required: bytes 8'hA5 then 8'hC3, on consecutive cycles starting 2 cycles after `fifo_rd`.
   - Then: `word_cnt` = 1, return to IDLE, `busy` = 0.
2. **Byte order.** Same as test 1 with `HI_FIRST` = 0.
   - Required: 8'hC3 then 8'hA5.
3. **Burst.** Preload 64 words 0..63 and drain with `out_ready` = 1.
   - Required: 128 bytes in order, one word every 3 cycles, `fifo_rd` never high while `fifo_empty` is high.
   - Then: `word_cnt` = 64, `err` = 0.
4. **Backpressure.** Drive `out_ready` with a random 50% pattern.
   - Required: `out_data` is stable during every stall, no byte is lost or duplicated, and the byte sequence matches the input.
5. **Reset mid-word.** Assert `rst` for one cycle while in BYTE1.
   - Required: outputs at reset values the next cycle, the held word is dropped, and `word_cnt` = 0.
6. **Error flag.** Force `fifo_udfl` = 1 for one cycle.
   - Required: `err` = 1 and held.
   - `err_clr` pulse: `err` = 0.
   - `err_clr` and `fifo_udfl` in the same cycle: `err` = 0.
7. **Counter wrap.** With `CNT_W` = 4, drain 17 words.
   - Required: `word_cnt` = 1.
